// File: rtl/ctrl_retire_monitor.sv
// Passive retire monitor for the multicycle MIPS control bus.
// Rebuilds instruction boundaries, classifies retires, counts, and latches the first violation.
module ctrl_retire_monitor #(
   parameter int CNT_W   = 32,
   parameter int MAX_CYC = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      ctrl,
   input  logic [5:0]       op,
   input  logic             zero,
   output logic             retire,
   output logic [2:0]       retire_class,
   output logic             branch_taken,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic             err,
   output logic [2:0]       err_code
);
   // state | meaning
   // IDLE  | waiting for a fetch word
   // DEC   | fetch seen, decode word required next
   // EXEC  | decoded, counting cycles until the retire word
   typedef enum logic [1:0] {IDLE, DEC, EXEC} state_t;

   localparam int LEN_W = $clog2(MAX_CYC + 2);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CYC);

   localparam logic [2:0] CLS_R   = 3'd0;
   localparam logic [2:0] CLS_LW  = 3'd1;
   localparam logic [2:0] CLS_SW  = 3'd2;
   localparam logic [2:0] CLS_BR  = 3'd3;
   localparam logic [2:0] CLS_IMM = 3'd4;
   localparam logic [2:0] CLS_J   = 3'd5;
   localparam logic [2:0] CLS_UNK = 3'd7;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt, cur_len, req_len;
   logic [5:0]       cls_op, cls_op_nxt;
   logic [2:0]       cls, cls_nxt, dec_cls;
   logic             fetchw, decw, retw;
   logic             ret_nxt, taken_nxt;
   logic             err_hit;
   logic [2:0]       err_hit_code;
   logic             unused_ctrl;

   assign unused_ctrl = ^{ctrl[11], ctrl[8:7], ctrl[2:0]};

   assign fetchw = ctrl[15] & ctrl[13] & ~ctrl[9];
   assign decw   = ~ctrl[15] & ~ctrl[14] & ~ctrl[13] & ~ctrl[12] & (ctrl[6:5] == 2'b11);
   assign retw   = ctrl[12] | ctrl[14] | ctrl[10] | (ctrl[15] & (ctrl[4:3] == 2'b10));

   // len counts words already accepted; the word on the bus now is word len+1
   assign cur_len = len + LEN_W'(1);

   always_comb begin
      dec_cls = CLS_UNK;
      case (op)
         6'b000000:                                  dec_cls = CLS_R;
         6'b100011:                                  dec_cls = CLS_LW;
         6'b101011:                                  dec_cls = CLS_SW;
         OP_BEQ, OP_BNE:                             dec_cls = CLS_BR;
         6'b001000, 6'b001101, 6'b001100, 6'b001010: dec_cls = CLS_IMM;
         6'b000010:                                  dec_cls = CLS_J;
         default:                                    dec_cls = CLS_UNK;
      endcase
   end

   always_comb begin
      req_len = LEN_W'(4);
      case (cls)
         CLS_LW:        req_len = LEN_W'(5);
         CLS_BR, CLS_J: req_len = LEN_W'(3);
         default:       req_len = LEN_W'(4);
      endcase
   end

   always_comb begin
      taken_nxt = (cls == CLS_J);
      if (cls_op == OP_BEQ)      taken_nxt = zero;
      else if (cls_op == OP_BNE) taken_nxt = ~zero;
   end

   always_comb begin
      state_nxt    = state;
      len_nxt      = len;
      cls_op_nxt   = cls_op;
      cls_nxt      = cls;
      ret_nxt      = 1'b0;
      err_hit      = 1'b0;
      err_hit_code = 3'd0;
      case (state)
         IDLE: begin
            if (fetchw) begin
               state_nxt = DEC;
               len_nxt   = LEN_W'(1);
            end
         end
         DEC: begin
            if (decw) begin
               state_nxt  = EXEC;
               len_nxt    = cur_len;
               cls_op_nxt = op;
               cls_nxt    = dec_cls;
               if (dec_cls == CLS_UNK) begin
                  err_hit      = 1'b1;
                  err_hit_code = 3'd5;
               end
            end else begin
               state_nxt    = IDLE;
               len_nxt      = '0;
               err_hit      = 1'b1;
               err_hit_code = 3'd1;
            end
         end
         EXEC: begin
            if (retw) begin
               ret_nxt   = 1'b1;
               state_nxt = IDLE;
               len_nxt   = '0;
               // unknown opcodes have no defined length; err 5 already covers them
               if (cls != CLS_UNK && cur_len != req_len) begin
                  err_hit      = 1'b1;
                  err_hit_code = 3'd3;
               end
            end else if (fetchw) begin
               state_nxt    = DEC;
               len_nxt      = LEN_W'(1);
               err_hit      = 1'b1;
               err_hit_code = 3'd2;
            end else if (cur_len > MAX_LEN) begin
               state_nxt    = IDLE;
               len_nxt      = '0;
               err_hit      = 1'b1;
               err_hit_code = 3'd4;
            end else begin
               len_nxt = cur_len;
            end
         end
         default: begin
            state_nxt = IDLE;
            len_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         len    <= '0;
         cls_op <= '0;
         cls    <= CLS_R;
      end else begin
         state  <= state_nxt;
         len    <= len_nxt;
         cls_op <= cls_op_nxt;
         cls    <= cls_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retire       <= 1'b0;
         retire_class <= 3'd0;
         branch_taken <= 1'b0;
         instr_count  <= '0;
         cycle_count  <= '0;
         err          <= 1'b0;
         err_code     <= 3'd0;
      end else begin
         retire      <= ret_nxt;
         cycle_count <= cycle_count + CNT_W'(1);
         if (ret_nxt) begin
            retire_class <= cls;
            branch_taken <= taken_nxt;
            instr_count  <= instr_count + CNT_W'(1);
         end
         if (err_hit && !err) begin
            err      <= 1'b1;
            err_code <= err_hit_code;
         end
      end
   end
endmodule

// File: doc/ctrl_retire_monitor.md
# ctrl_retire_monitor

Passive monitor on the multicycle MIPS controller's 16-bit control bus. It reads the per-cycle control word and the instruction-register opcode. From these it reconstructs instruction boundaries, emits a one-cycle retire pulse with an instruction class, and keeps retired-instruction and cycle counters. It also latches the first sequencing violation it detects. It sits beside the controller/datapath pair, drives nothing back into them, and feeds the debug and testbench scoreboards.

## Interface

Parameters:
- CNT_W, 32, width of `instr_count` and `cycle_count`.
- MAX_CYC, 8, watchdog limit in cycles from the fetch word to the retire word, inclusive.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- ctrl  in  16  control word: [15] pcwrite, [14] memwrite, [13] irwrite, [12] regwrite, [11] alusrca, [10] branch, [9] iord, [8] memtoreg, [7] regdst, [6:5] alusrcb, [4:3] pcsrc, [2:0] aluop.
- op  in  6  instruction-register opcode, valid from the decode cycle onward.
- zero  in  1  ALU zero flag.
- retire  out  1  one-cycle pulse: an instruction completed.
- retire_class  out  3  0 R-type, 1 lw, 2 sw, 3 branch (beq/bne), 4 imm (addi/ori/andi/slti), 5 j, 7 unknown.
- branch_taken  out  1  valid with `retire`; 1 = branch/jump redirected the PC.
- instr_count  out  CNT_W  retired instructions since reset; wraps.
- cycle_count  out  CNT_W  cycles since reset; wraps.
- err  out  1  sticky violation flag.
- err_code  out  3  code of the first violation; sticky.

## Operation

Word classification (combinational on `ctrl`):
- FETCHW: pcwrite & irwrite & !iord.
- DECW: pcwrite, memwrite, irwrite and regwrite all 0, and alusrcb = 2'b11.
- RETW: regwrite, or memwrite, or branch, or (pcwrite & pcsrc = 2'b10).

Monitor FSM:
- IDLE (reset state): ignore all words except FETCHW. On FETCHW go to DEC and set len = 1.
- DEC: DECW required. On DECW, latch op into cls_op and map it to a class. Map unlisted opcodes to class 7 and raise err 5. Go to EXEC. Any non-DECW word raises err 1 and returns the FSM to IDLE.
- EXEC: len increments each cycle.
  - On RETW: pulse `retire` and go to IDLE.
  - On FETCHW without a prior RETW: raise err 2, then treat the word as a new fetch (len = 1, go to DEC).
  - If len exceeds MAX_CYC: raise err 4 and go to IDLE.
- Required length (fetch to retire word, inclusive) per class:
  - lw 5
  - sw, R, imm 4
  - branch, j 3
- At retire, a length mismatch raises err 3. `retire` still pulses.

Outputs and counters:
- branch_taken:
  - cls_op = 000100 (beq): zero.
  - cls_op = 000101 (bne): !zero.
  - j: 1.
  - All other classes: 0.
  - `zero` is sampled in the retire-word cycle.
- instr_count increments on every retire, including erroneous ones.
- cycle_count increments every non-reset cycle.
- err/err_code record only the first violation. Later violations are ignored until reset.

## Timing

- All outputs are registered. `retire`, `retire_class` and `branch_taken` assert in the cycle after the retire word is on `ctrl`. `instr_count` shows the new value in that same cycle.
- `retire_class` and `branch_taken` hold their last values between pulses.
- `err` asserts in the cycle after the offending word.
- Reset values: retire 0, retire_class 0, branch_taken 0, instr_count 0, cycle_count 0, err 0, err_code 0, FSM IDLE, len 0.
- Reset mid-instruction discards the open instruction: no retire and no error. Tracking resumes at the next FETCHW.
- Counters wrap from 2^CNT_W-1 to 0 without flagging.
- Back-to-back instructions: a retire word followed immediately by FETCHW is legal. Retire of instruction N and DEC of instruction N+1 overlap by one cycle.

## Test plan

- lw sequence (fetch 0xA020, decode 0x0060, 0x0840, 0x0200, 0x1100), op=100011 -> one retire pulse the cycle after 0x1100, class 1, instr_count 1, err 0.
- beq (fetch, decode, 0x0C09) with op=000100 and zero=1, then bne (fetch, decode, 0x0C0B) with op=000101 and zero=1 -> retires class 3 with branch_taken 1, then 0; instr_count 2.
- Fetch followed by 0x0000 instead of decode -> err 1, err_code 1, no retire. Later valid instructions still retire, and err_code stays 1.
- Fetch, decode, then ctrl held at 0x0840 for 10 cycles with MAX_CYC=8 -> err_code 4 after the len-9 cycle, FSM IDLE.
- R-type retired at length 5 (extra 0x0802 cycle) -> retire class 0 plus err_code 3.
- Reset asserted during an addi EXEC cycle -> all outputs 0 next cycle. A following full addi (fetch, decode, 0x0840, 0x1000) retires class 4, instr_count 1, err 0.
